// File: rtl/vec_alu_array.sv
// Multi-lane vector integer ALU: IDLE/RUN/DONE sequencer processing NL elements per RUN cycle.
// Defining VEC_ALU_ARRAY_MASK_EN adds the vm/v0 element-mask inputs.
module vec_alu_array #(
   parameter int unsigned VLEN          = 128,
   parameter int unsigned NB_LANES_LOG2 = 2,
   parameter int unsigned ELEN_LOG2     = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      opcode,
   input  logic [2:0]      op_type,
   input  logic [2:0]      vsew,
   input  logic [10:0]     vl,
   input  logic [VLEN-1:0] vs1,
   input  logic [VLEN-1:0] vs2,
   input  logic [VLEN-1:0] vd_old,
   input  logic [31:0]     rs1,
   input  logic [4:0]      imm,
`ifdef VEC_ALU_ARRAY_MASK_EN
   input  logic            vm,
   input  logic [VLEN-1:0] v0,
`endif
   output logic [VLEN-1:0] vd,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int unsigned NL     = 1 << NB_LANES_LOG2;
   localparam int unsigned CNT_W  = $clog2(VLEN / 8 + 1);
   localparam int unsigned BASE_W = CNT_W + 4;
   localparam int unsigned OFF_W  = BASE_W + 6;
   localparam int unsigned SH_W   = $clog2(VLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  grp_q, grp_d, vle_q, vle_d, vle_in;
   logic [5:0]        opc_q, opc_d;
   logic [2:0]        opt_q, opt_d, sew_q, sew_d;
   logic [VLEN-1:0]   vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
   logic [31:0]       rs1_q, rs1_d;
   logic [4:0]        imm_q, imm_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [10:0]       vlmax_in;
   logic              legal_op, legal_in, last_grp;
   logic [BASE_W-1:0] grp_base;
`ifdef VEC_ALU_ARRAY_MASK_EN
   logic              vm_q, vm_d;
   logic [VLEN-1:0]   v0_q, v0_d;
`endif

   function automatic logic [63:0] sew_mask(input logic [2:0] sew);
      case (sew)
         3'd0:    return 64'h0000_0000_0000_00FF;
         3'd1:    return 64'h0000_0000_0000_FFFF;
         3'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return '1;
      endcase
   endfunction

   function automatic logic [63:0] sext(input logic [63:0] x, input logic [2:0] sew);
      case (sew)
         3'd0:    return {{56{x[7]}}, x[7:0]};
         3'd1:    return {{48{x[15]}}, x[15:0]};
         3'd2:    return {{32{x[31]}}, x[31:0]};
         default: return x;
      endcase
   endfunction

   // One element operation at width SEW; result is confined to the low SEW bits.
   function automatic logic [63:0] alu(input logic [5:0] opc, input logic [2:0] sew,
                                       input logic [63:0] a, input logic [63:0] b);
      logic [63:0] m, sa, sb, r;
      logic        lt_u, lt_s;
      m    = sew_mask(sew);
      sa   = sext(a, sew);
      sb   = sext(b, sew);
      lt_u = (a & m) < (b & m);
      lt_s = $signed(sa) < $signed(sb);
      case (opc)
         6'b000000: r = a + b;
         6'b000010: r = a - b;
         6'b000100: r = lt_u ? a : b;
         6'b000101: r = lt_s ? a : b;
         6'b000110: r = lt_u ? b : a;
         6'b000111: r = lt_s ? b : a;
         6'b001001: r = a & b;
         6'b001010: r = a | b;
         6'b001011: r = a ^ b;
         default:   r = '0;
      endcase
      return r & m;
   endfunction

   // Merge the result of element idx into acc when it is active (and unmasked).
   function automatic logic [VLEN-1:0] write_lane(input logic [VLEN-1:0] acc,
                                                  input logic [BASE_W-1:0] idx);
      logic [OFF_W-1:0] off;
      logic [63:0]      m, a, b, res;
      logic             wr;
      off = OFF_W'(idx) << ({1'b0, sew_q} + 4'd3);
      m   = sew_mask(sew_q);
      a   = 64'(vs2_q >> off);
      case (opt_q)
         3'b001:  b = 64'(vs1_q >> off);
         3'b010:  b = 64'(rs1_q);
         default: b = {{59{imm_q[4]}}, imm_q};
      endcase
      wr = BASE_W'(vle_q) > idx;
`ifdef VEC_ALU_ARRAY_MASK_EN
      wr = wr && (vm_q || v0_q[SH_W'(idx)]);
`endif
      res = alu(opc_q, sew_q, a & m, b & m);
      if (wr) return (acc & ~(VLEN'(m) << off)) | (VLEN'(res) << off);
      return acc;
   endfunction

   // Legality and effective length of the request presented on the start edge.
   always_comb begin : start_decode
      case (vsew)
         3'd0:    vlmax_in = 11'(VLEN / 8);
         3'd1:    vlmax_in = 11'(VLEN / 16);
         3'd2:    vlmax_in = 11'(VLEN / 32);
         3'd3:    vlmax_in = 11'(VLEN / 64);
         default: vlmax_in = '0;
      endcase
      vle_in = (vl < vlmax_in) ? CNT_W'(vl) : CNT_W'(vlmax_in);
      case (opcode)
         6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b000110,
         6'b000111, 6'b001001, 6'b001010, 6'b001011: legal_op = 1'b1;
         default:                                    legal_op = 1'b0;
      endcase
      legal_in = legal_op && (op_type inside {3'b001, 3'b010, 3'b100}) &&
                 ((32'(vsew) + 32'd3) <= ELEN_LOG2);
   end

   always_comb begin : next_state
      state_d  = state_q;
      grp_d    = grp_q;
      vle_d    = vle_q;
      opc_d    = opc_q;
      opt_d    = opt_q;
      sew_d    = sew_q;
      vs1_d    = vs1_q;
      vs2_d    = vs2_q;
      rs1_d    = rs1_q;
      imm_d    = imm_q;
      vd_d     = vd_q;
      err_d    = err_q;
`ifdef VEC_ALU_ARRAY_MASK_EN
      vm_d     = vm_q;
      v0_d     = v0_q;
`endif
      grp_base = BASE_W'(grp_q) << NB_LANES_LOG2;
      last_grp = (grp_base + BASE_W'(NL)) >= BASE_W'(vle_q);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opc_d   = opcode;
               opt_d   = op_type;
               sew_d   = vsew;
               vle_d   = vle_in;
               vs1_d   = vs1;
               vs2_d   = vs2;
               rs1_d   = rs1;
               imm_d   = imm;
               vd_d    = vd_old;
               err_d   = !legal_in;
               grp_d   = '0;
`ifdef VEC_ALU_ARRAY_MASK_EN
               vm_d    = vm;
               v0_d    = v0;
`endif
               state_d = (legal_in && (vle_in != '0)) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            for (int j = 0; j < int'(NL); j++) begin
               vd_d = write_lane(vd_d, grp_base + BASE_W'(j));
            end
            grp_d = grp_q + CNT_W'(1);
            if (last_grp) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            grp_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin : regs
      if (reset) begin
         state_q <= S_IDLE;
         grp_q   <= '0;
         vle_q   <= '0;
         opc_q   <= '0;
         opt_q   <= '0;
         sew_q   <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         rs1_q   <= '0;
         imm_q   <= '0;
         vd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef VEC_ALU_ARRAY_MASK_EN
         vm_q    <= 1'b0;
         v0_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         vle_q   <= vle_d;
         opc_q   <= opc_d;
         opt_q   <= opt_d;
         sew_q   <= sew_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         rs1_q   <= rs1_d;
         imm_q   <= imm_d;
         vd_q    <= vd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef VEC_ALU_ARRAY_MASK_EN
         vm_q    <= vm_d;
         v0_q    <= v0_d;
`endif
      end
   end

   assign vd   = vd_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_vec_alu_array.sv
// Randomized self-checking bench for vec_alu_array against an element-level reference model.
// Exercises the mask ports too when VEC_ALU_ARRAY_MASK_EN is defined.
module tb_vec_alu_array;

   localparam int unsigned VLEN = 128;
   localparam int unsigned NL   = 4;
   localparam int unsigned ELEN = 32;

   logic            clk, reset, start;
   logic [5:0]      opcode;
   logic [2:0]      op_type, vsew;
   logic [10:0]     vl;
   logic [VLEN-1:0] vs1, vs2, vd_old, vd;
   logic [31:0]     rs1;
   logic [4:0]      imm;
   logic            busy, done, err;
`ifdef VEC_ALU_ARRAY_MASK_EN
   logic            vm;
   logic [VLEN-1:0] v0;
`endif

   int              n_chk, n_pass, da;
   bit              chk_en;
   logic            exp_busy, exp_done, exp_err, m_err, mvm;
   logic [VLEN-1:0] exp_vd, m_vd, mv0, old, a1, a2;
   logic [5:0]      r_opc;
   logic [2:0]      r_ot, r_vs;
   logic [10:0]     r_vl;

   vec_alu_array #(.VLEN(VLEN), .NB_LANES_LOG2(2), .ELEN_LOG2(5)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op_type(op_type),
      .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2), .vd_old(vd_old), .rs1(rs1), .imm(imm),
`ifdef VEC_ALU_ARRAY_MASK_EN
      .vm(vm), .v0(v0),
`endif
      .vd(vd), .busy(busy), .done(done), .err(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, expv);
   endtask

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] r;
      for (int i = 0; i < int'(VLEN / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [5:0] pick_op(input int k);
      case (k)
         0: return 6'b000000;  1: return 6'b000010;  2: return 6'b000100;
         3: return 6'b000101;  4: return 6'b000110;  5: return 6'b000111;
         6: return 6'b001001;  7: return 6'b001010;  default: return 6'b001011;
      endcase
   endfunction

   function automatic bit is_legal(input logic [5:0] opc, input logic [2:0] ot, input int sew);
      bit ok_op;
      ok_op = 1'b0;
      for (int k = 0; k < 9; k++) if (pick_op(k) == opc) ok_op = 1'b1;
      return ok_op && $onehot(ot) && (sew <= int'(ELEN));
   endfunction

   function automatic longint unsigned get_elem(input logic [VLEN-1:0] v, input int i, input int sew);
      longint unsigned r = 0;
      for (int b = 0; b < sew; b++) r[b] = v[i*sew + b];
      return r;
   endfunction

   // Reference element operation using plain integer arithmetic.
   function automatic longint unsigned ref_alu(input logic [5:0] opc, input int sew,
                                               input longint unsigned ai, input longint unsigned bi);
      longint unsigned m, a, b, r;
      longint          sa, sb;
      m  = (sew >= 64) ? '1 : ((64'd1 << sew) - 64'd1);
      a  = ai & m;
      b  = bi & m;
      sa = a[sew-1] ? longint'(a | ~m) : longint'(a);
      sb = b[sew-1] ? longint'(b | ~m) : longint'(b);
      case (opc)
         6'b000000: r = a + b;
         6'b000010: r = a - b;
         6'b000100: r = (a < b) ? a : b;
         6'b000101: r = (sa < sb) ? a : b;
         6'b000110: r = (a > b) ? a : b;
         6'b000111: r = (sa > sb) ? a : b;
         6'b001001: r = a & b;
         6'b001010: r = a | b;
         default:   r = a ^ b;
      endcase
      return r & m;
   endfunction

   // Destination after the first lim elements have been processed.
   function automatic logic [VLEN-1:0] model_vd(input logic [VLEN-1:0] o, s1, s2,
         input logic [31:0] x, input logic [4:0] im, input logic [5:0] opc, input logic [2:0] ot,
         input int sew, input int lim, input logic vmask, input logic [VLEN-1:0] msk);
      logic [VLEN-1:0] r;
      longint unsigned b, res;
      r = o;
      for (int i = 0; i < lim; i++) begin
         if (!vmask && !msk[i]) continue;
         if (ot == 3'b001)      b = get_elem(s1, i, sew);
         else if (ot == 3'b010) b = longint'(x);
         else                   b = im[4] ? (64'hFFFF_FFFF_FFFF_FFE0 | 64'(im)) : 64'(im);
         res = ref_alu(opc, sew, get_elem(s2, i, sew), b);
         for (int bt = 0; bt < sew; bt++) r[i*sew + bt] = res[bt];
      end
      return r;
   endfunction

   task automatic scramble();
      opcode = 6'($urandom); op_type = 3'($urandom); vsew = 3'($urandom); vl = 11'($urandom);
      vs1 = rand_vec(); vs2 = rand_vec(); vd_old = rand_vec(); rs1 = $urandom; imm = 5'($urandom);
`ifdef VEC_ALU_ARRAY_MASK_EN
      vm = 1'($urandom); v0 = rand_vec();
`endif
   endtask

   // Called at posedge+1 of an IDLE cycle; returns the edge at which done was first sampled high.
   task automatic run_op(input logic [5:0] opc, input logic [2:0] ot, input logic [2:0] vs,
         input logic [10:0] l, input logic [VLEN-1:0] s1, s2, o, input logic [31:0] x,
         input logic [4:0] im, input logic vmask, input logic [VLEN-1:0] msk, output int done_at);
      int sew, vle, n, lim;
      bit legal;
      sew   = 8 << vs;
      legal = is_legal(opc, ot, sew);
      vle   = (int'(l) < int'(VLEN) / sew) ? int'(l) : int'(VLEN) / sew;
      n     = (legal && vle > 0) ? (vle + int'(NL) - 1) / int'(NL) : 0;
      done_at  = -1;
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = m_err; exp_vd = m_vd;
      opcode = opc; op_type = ot; vsew = vs; vl = l; vs1 = s1; vs2 = s2; vd_old = o;
      rs1 = x; imm = im;
`ifdef VEC_ALU_ARRAY_MASK_EN
      vm = vmask; v0 = msk;
`endif
      start = 1'b1;
      for (int k = 0; k <= n + 1; k++) begin
         @(posedge clk); #1;
         if (k == 0) scramble();
         start    = (k <= n) ? 1'($urandom) : 1'b0;
         lim      = (k < n) ? k * int'(NL) : (legal ? vle : 0);
         exp_vd   = model_vd(o, s1, s2, x, im, opc, ot, sew, lim, vmask, msk);
         exp_busy = (k <= n);
         exp_done = (k == n);
         exp_err  = !legal;
         if (done === 1'b1 && done_at < 0) done_at = k + 1;
      end
      m_vd  = exp_vd;
      m_err = exp_err;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", VLEN'(busy), VLEN'(exp_busy));
         chk("done", VLEN'(done), VLEN'(exp_done));
         chk("err", VLEN'(err), VLEN'(exp_err));
         chk("vd", vd, exp_vd);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_pass = 0; chk_en = 1'b0;
      mvm = 1'b1; mv0 = '0;
      reset = 1'b1; start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_vd", vd, '0);
      chk("reset_busy", VLEN'(busy), '0);
      chk("reset_done", VLEN'(done), '0);
      chk("reset_err", VLEN'(err), '0);
      reset = 1'b0; m_vd = '0; m_err = 1'b0; chk_en = 1'b1;

      // vadd VV SEW32
      a1 = {32'd4, 32'd3, 32'd2, 32'd1}; a2 = {32'd40, 32'd30, 32'd20, 32'd10};
      run_op(6'b000000, 3'b001, 3'd2, 11'd4, a1, a2, rand_vec(), $urandom, 5'($urandom), mvm, mv0, da);
      chk("vadd_vv_vd", vd, 128'h0000002c_00000021_00000016_0000000b);
      chk("vadd_vv_done_edge", VLEN'(da), VLEN'(2));

      // vand VI SEW8
      a2 = {16{8'hAB}};
      run_op(6'b001001, 3'b100, 3'd0, 11'd16, rand_vec(), a2, rand_vec(), $urandom, 5'h0F, mvm, mv0, da);
      chk("vand_vi_vd", vd, {16{8'h0B}});
      chk("vand_vi_done_edge", VLEN'(da), VLEN'(5));

      // vadd VX SEW16 with tail
      a2 = {8{16'h0001}}; old = {8{16'hAAAA}};
      run_op(6'b000000, 3'b010, 3'd1, 11'd5, rand_vec(), a2, old, 32'h1234FFFF, 5'($urandom), mvm, mv0, da);
      chk("vadd_vx_vd", vd, {{3{16'hAAAA}}, {5{16'h0000}}});
      chk("vadd_vx_done_edge", VLEN'(da), VLEN'(3));

      // vl = 0 and SEW above ELEN
      old = rand_vec();
      run_op(6'b000000, 3'b001, 3'd2, 11'd0, rand_vec(), rand_vec(), old, $urandom, 5'($urandom), mvm, mv0, da);
      chk("vl0_vd", vd, old);
      chk("vl0_err", VLEN'(err), '0);
      chk("vl0_done_edge", VLEN'(da), VLEN'(1));
      old = rand_vec();
      run_op(6'b000000, 3'b001, 3'd3, 11'd2, rand_vec(), rand_vec(), old, $urandom, 5'($urandom), mvm, mv0, da);
      chk("sew64_vd", vd, old);
      chk("sew64_err", VLEN'(err), VLEN'(1));
      chk("sew64_done_edge", VLEN'(da), VLEN'(1));

`ifdef VEC_ALU_ARRAY_MASK_EN
      a1 = {32'd4, 32'd3, 32'd2, 32'd1}; a2 = {32'd40, 32'd30, 32'd20, 32'd10};
      run_op(6'b000000, 3'b001, 3'd2, 11'd4, a1, a2, '0, $urandom, 5'($urandom), 1'b0, VLEN'(5), da);
      chk("masked_vd", vd, 128'h00000000_00000021_00000000_0000000b);
`endif

      for (int t = 0; t < 150; t++) begin
         r_opc = ($urandom_range(0, 9) != 0) ? pick_op(int'($urandom_range(0, 8))) : 6'($urandom);
         r_ot  = ($urandom_range(0, 9) != 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
         r_vs  = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
         r_vl  = ($urandom_range(0, 4) != 0) ? 11'($urandom_range(0, 20)) : 11'($urandom);
`ifdef VEC_ALU_ARRAY_MASK_EN
         mvm = 1'($urandom); mv0 = rand_vec();
`endif
         run_op(r_opc, r_ot, r_vs, r_vl, rand_vec(), rand_vec(), rand_vec(), $urandom,
                5'($urandom), mvm, mv0, da);
      end
      mvm = 1'b1;

      // Reset in the middle of a RUN phase
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = m_err; exp_vd = m_vd;
      old = rand_vec();
      opcode = 6'b001001; op_type = 3'b100; vsew = 3'd0; vl = 11'd16; vs2 = {16{8'hAB}};
      imm = 5'h0F; vd_old = old;
`ifdef VEC_ALU_ARRAY_MASK_EN
      vm = 1'b1;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; exp_busy = 1'b1; exp_err = 1'b0; exp_vd = old;
      @(posedge clk); #1;
      exp_vd = {old[127:32], {4{8'h0B}}};
      #2;
      chk_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk("midrst_vd", vd, '0);
      chk("midrst_busy", VLEN'(busy), '0);
      chk("midrst_done", VLEN'(done), '0);
      chk("midrst_err", VLEN'(err), '0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_hold_done", VLEN'(done), '0);
         chk("midrst_hold_busy", VLEN'(busy), '0);
      end
      reset = 1'b0; m_vd = '0; m_err = 1'b0; chk_en = 1'b1;
      a1 = {32'd4, 32'd3, 32'd2, 32'd1}; a2 = {32'd40, 32'd30, 32'd20, 32'd10};
      run_op(6'b000000, 3'b001, 3'd2, 11'd4, a1, a2, rand_vec(), $urandom, 5'($urandom), mvm, mv0, da);
      chk("post_rst_vd", vd, 128'h0000002c_00000021_00000016_0000000b);
      chk("post_rst_done_edge", VLEN'(da), VLEN'(2));

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vec_alu_array.md
VEC_ALU_ARRAY -- requirements
Module: vec_alu_array

Interface
REQ-001 Parameter VLEN, default 128: vector register width in bits, a power of two from 64 to 1024.
REQ-002 Parameter NB_LANES_LOG2, default 2: log2 of the lane count NL, from 0 to 3.
REQ-003 Parameter ELEN_LOG2, default 5: log2 of the maximum element width ELEN, either 5 or 6.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a new operation; sampled only in IDLE.
REQ-007 opcode  in  6  RVV funct6 code of the operation.
REQ-008 op_type  in  3  one-hot operand source: 001 VV, 010 VX, 100 VI.
REQ-009 vsew  in  3  element width code; SEW = 8 << vsew.
REQ-010 vl  in  11  number of active elements.
REQ-011 vs1, vs2, vd_old  in  VLEN each  source vectors and the old destination vector.
REQ-012 rs1  in  32  scalar operand; imm  in  5  immediate operand.
REQ-013 vd  out  VLEN  result vector; busy  out  1  operation in progress; done  out  1  one-cycle completion pulse; err  out  1  illegal operation flag.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE: IDLE moves to RUN on start; RUN moves to DONE after its last group; DONE moves to IDLE after one cycle.
REQ-015 On the start edge the block SHALL latch opcode, op_type, vsew, vl, vs1, vs2, vd_old, rs1 and imm; input changes after that edge SHALL NOT affect the result.
REQ-016 The effective vl SHALL be vle = min(vl, VLEN/SEW).
REQ-017 RUN SHALL last ceil(vle/NL) cycles; RUN cycle k SHALL write elements k*NL through k*NL+NL-1, limited to indices below vle.
REQ-018 When vle = 0, or when the operation is illegal, the block SHALL go from IDLE directly to DONE, with no RUN cycles.
REQ-019 Operations by opcode (only these are legal):
- 000000 vadd: vs2 + op.
- 000010 vsub: vs2 - op.
- 000100 vminu; 000101 vmin: unsigned / signed minimum.
- 000110 vmaxu; 000111 vmax: unsigned / signed maximum.
- 001001 vand; 001010 vor; 001011 vxor.
REQ-020 Operand op SHALL be selected as follows:
- VV: the vs1 element.
- VX: rs1 truncated to SEW bits.
- VI: imm sign-extended to SEW bits.
REQ-021 Arithmetic SHALL be modulo 2^SEW, with no saturation and no carry into the neighbouring element.
REQ-022 Tail elements (index >= vle) SHALL take their value from the latched vd_old.
REQ-023 The operation SHALL be illegal when the opcode is not listed in REQ-019, when op_type is not one-hot, or when SEW > ELEN.
- In DONE: err = 1 and vd = latched vd_old.
REQ-024 busy SHALL be 1 in RUN and DONE; done SHALL be 1 only in DONE.
REQ-025 vd SHALL hold its value from DONE until the next start edge, and SHALL be loaded with the latched vd_old on that start edge.
REQ-026 start asserted while busy = 1 SHALL be ignored and not queued.
REQ-027 err SHALL clear on the next accepted start.

Reset
REQ-028 On reset assertion the block SHALL, asynchronously:
- go to IDLE;
- drive vd = 0, busy = 0, done = 0, err = 0;
- clear the group counter.
REQ-029 Reset in the middle of an operation SHALL abort it with no done pulse; start SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-030 When macro VEC_ALU_ARRAY_MASK_EN is defined, the block SHALL add inputs vm (1 bit) and v0 (VLEN bits), both latched at start.
- If vm = 0 and bit i of v0 is 0, active element i SHALL keep its vd_old value.
- Ports vm and v0 SHALL NOT exist when the macro is undefined.
REQ-031 Without VEC_ALU_ARRAY_MASK_EN, all active elements SHALL be written.

Verification
(Defaults VLEN = 128, NL = 4, ELEN = 32; start is sampled at edge 0.)
REQ-032 vadd VV, SEW 32, vl = 4, vs1 = {4,3,2,1}, vs2 = {40,30,20,10} -> one RUN cycle, done at edge 2, vd = 0000002c_00000021_00000016_0000000b.
REQ-033 vand VI, SEW 8, vl = 16, imm = 0x0F, vs2 bytes all 0xAB -> 4 RUN cycles, done at edge 5, vd bytes all 0x0B.
REQ-034 vadd VX, SEW 16, vl = 5, rs1 = 0x1234FFFF, vs2 halfwords all 0x0001, vd_old halfwords all 0xAAAA -> halfwords 0 to 4 = 0x0000, halfwords 5 to 7 = 0xAAAA, done at edge 3.
REQ-035 vl = 0, and separately vsew = 3 with ELEN = 32 -> done at edge 1, vd = vd_old; err = 0 for vl = 0, err = 1 for vsew = 3.
REQ-036 Reset asserted during RUN of REQ-033 -> outputs go to 0 immediately, no done pulse; a new start after deassertion completes normally.
REQ-037 With VEC_ALU_ARRAY_MASK_EN, vm = 0, v0 = 0x5, stimulus as in REQ-032, vd_old all zeros -> vd = 00000000_00000021_00000000_0000000b.
